csync_vsync_sep: RTL and testbench

Composite-sync vertical separator. It sits directly upstream of the PAL/NTSC VSYNC-period detector. It watches `csync_in`, measures every low pulse, and classifies each one as a normal (hsync/equalising) pulse or a broad (vertical serration) pulse. From that classification it regenerates an active-low `vsync_out` whose falling edge marks field start. It also reports the line count of the last field and, optionally, loss of sync.

---
 rtl/csync_vsync_sep.sv | 174 +++++++++++++++++
 tb/tb_csync_vsync_sep.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/csync_vsync_sep.sv
// Composite-sync vertical separator: classifies csync low pulses as normal/broad and regenerates vsync.
// Optional loss-of-sync timer enabled by defining SYNC_LOSS_EN.
module csync_vsync_sep #(
  parameter int unsigned CLK_FREQ    = 250_000,
  parameter int unsigned BROAD_US    = 15,
  parameter int unsigned BROAD_COUNT = 3,
  parameter int unsigned LOSS_US     = 1000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       csync_in,
  output logic       vsync_out,
  output logic [9:0] lines_per_field,
  output logic       sync_lost
);

  localparam int unsigned BROAD_TICKS = (CLK_FREQ / 1000) * BROAD_US / 1000;
  localparam int unsigned LOSS_TICKS  = (CLK_FREQ / 1000) * LOSS_US / 1000;
  localparam int unsigned WIDTH_W     = 8;
  localparam int unsigned BCNT_W      = 3;
  localparam int unsigned LINE_W      = 10;
  localparam int unsigned TIMER_W     = 16;

  // Elaboration-time sanity check of the derived constants
  if (BROAD_TICKS < 1 || BROAD_TICKS > 255 || BROAD_COUNT < 1 || BROAD_COUNT > 7 ||
      LOSS_TICKS < 1 || LOSS_TICKS > 65535) begin : g_param_check
    $error("csync_vsync_sep: derived constants out of range");
  end

  typedef enum logic {SEARCH, VSYNC} state_t;

  logic                sync1_q, cs_q, cs_dly_q;
  logic [2:0]          valid_q;
  logic                armed_q, armed_d;
  logic [WIDTH_W-1:0]  width_q, width_d;
  logic [BCNT_W-1:0]   broad_q, broad_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [LINE_W-1:0]   lpf_q, lpf_d;
  state_t              state_q, state_d;
  logic                vsync_q, vsync_d;
  logic                fall_c, rise_c, is_broad_c;
  logic [BCNT_W-1:0]   broad_inc_c;
  logic [LINE_W-1:0]   line_inc_c;
`ifdef SYNC_LOSS_EN
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                lost_q, lost_d;
`endif

  // valid_q[2] marks cs_dly_q as holding a real post-reset sample, hiding the reset-value edge
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1_q  <= 1'b1;
      cs_q     <= 1'b1;
      cs_dly_q <= 1'b1;
      valid_q  <= '0;
      armed_q  <= 1'b0;
      width_q  <= '0;
      broad_q  <= '0;
      line_q   <= '0;
      lpf_q    <= '0;
      state_q  <= SEARCH;
      vsync_q  <= 1'b1;
    end else begin
      sync1_q  <= csync_in;
      cs_q     <= sync1_q;
      cs_dly_q <= cs_q;
      valid_q  <= {valid_q[1:0], 1'b1};
      armed_q  <= armed_d;
      width_q  <= width_d;
      broad_q  <= broad_d;
      line_q   <= line_d;
      lpf_q    <= lpf_d;
      state_q  <= state_d;
      vsync_q  <= vsync_d;
    end
  end

`ifdef SYNC_LOSS_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      timer_q <= '0;
      lost_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      lost_q  <= lost_d;
    end
  end
`endif

  always_comb begin
    armed_d = armed_q;
    width_d = width_q;
    broad_d = broad_q;
    line_d  = line_q;
    lpf_d   = lpf_q;
    state_d = state_q;
    vsync_d = vsync_q;
`ifdef SYNC_LOSS_EN
    timer_d = timer_q;
    lost_d  = lost_q;
`endif

    fall_c      = valid_q[2] & cs_dly_q & ~cs_q;
    // A rise only ends a pulse whose fall was seen after reset
    rise_c      = valid_q[2] & armed_q & ~cs_dly_q & cs_q;
    is_broad_c  = (width_q >= WIDTH_W'(BROAD_TICKS));
    broad_inc_c = (broad_q == '1) ? broad_q : broad_q + BCNT_W'(1);
    line_inc_c  = (line_q == '1) ? line_q : line_q + LINE_W'(1);

    if (fall_c) begin
      width_d = WIDTH_W'(1);
      armed_d = 1'b1;
    end else if (!cs_q && width_q != '1) begin
      width_d = width_q + WIDTH_W'(1);
    end

    if (rise_c) begin
      if (is_broad_c) begin
        broad_d = broad_inc_c;
      end else begin
        broad_d = '0;
        line_d  = line_inc_c;
      end
    end

    unique case (state_q)
      SEARCH: begin
        if (rise_c && is_broad_c && broad_inc_c == BCNT_W'(BROAD_COUNT)) begin
          state_d = VSYNC;
          vsync_d = 1'b0;
          lpf_d   = line_q;
          line_d  = '0;
        end
      end
      VSYNC: begin
        if (rise_c && !is_broad_c) begin
          state_d = SEARCH;
          vsync_d = 1'b1;
          line_d  = LINE_W'(1);
        end
      end
      default: begin
        state_d = SEARCH;
        vsync_d = 1'b1;
      end
    endcase

`ifdef SYNC_LOSS_EN
    if (fall_c) begin
      timer_d = '0;
      lost_d  = 1'b0;
    end else begin
      if (timer_q != '1) timer_d = timer_q + TIMER_W'(1);
      // Timeout overrides any classification in the same cycle
      if (timer_q == TIMER_W'(LOSS_TICKS - 1)) begin
        lost_d  = 1'b1;
        state_d = SEARCH;
        vsync_d = 1'b1;
        broad_d = '0;
        line_d  = '0;
      end
    end
`endif
  end

  assign vsync_out       = vsync_q;
  assign lines_per_field = lpf_q;
`ifdef SYNC_LOSS_EN
  assign sync_lost       = lost_q;
`else
  assign sync_lost       = 1'b0;
`endif

endmodule

// File: tb/tb_csync_vsync_sep.sv
// Directed bench for csync_vsync_sep: pulse-group table plus hand sequences for timing, reset and sync-loss cases.
module tb_csync_vsync_sep;

  localparam int unsigned NVEC = 15;
  localparam int unsigned HIGH = 15;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       csync_in;
  logic       vsync_out;
  logic [9:0] lines_per_field;
  logic       sync_lost;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int unsigned low;
    int unsigned cnt;
    logic        exp_vs;
    logic [9:0]  exp_lpf;
  } vec_t;

  vec_t vecs [NVEC];

  csync_vsync_sep dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .csync_in        (csync_in),
    .vsync_out       (vsync_out),
    .lines_per_field (lines_per_field),
    .sync_lost       (sync_lost)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Caller is aligned to a negedge; returns aligned to a negedge
  task automatic pulse(input int unsigned low, input int unsigned high);
    csync_in = 1'b0;
    repeat (low) @(negedge clk_in);
    csync_in = 1'b1;
    repeat (high) @(negedge clk_in);
  endtask

  task automatic check_out(input string name, input logic vs, input logic [9:0] lpf);
    check({name, "_vsync"}, 16'(vsync_out), 16'(vs));
    check({name, "_lpf"}, 16'(lines_per_field), 16'(lpf));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{low: 1, cnt: 312, exp_vs: 1'b1, exp_lpf: 10'd0};
    vecs[1]  = '{low: 7, cnt: 2,   exp_vs: 1'b1, exp_lpf: 10'd0};
    vecs[2]  = '{low: 7, cnt: 1,   exp_vs: 1'b0, exp_lpf: 10'd312};
    vecs[3]  = '{low: 1, cnt: 1,   exp_vs: 1'b1, exp_lpf: 10'd312};
    vecs[4]  = '{low: 1, cnt: 262, exp_vs: 1'b1, exp_lpf: 10'd312};
    vecs[5]  = '{low: 7, cnt: 2,   exp_vs: 1'b1, exp_lpf: 10'd312};
    vecs[6]  = '{low: 7, cnt: 1,   exp_vs: 1'b0, exp_lpf: 10'd263};
    vecs[7]  = '{low: 7, cnt: 2,   exp_vs: 1'b0, exp_lpf: 10'd263};
    vecs[8]  = '{low: 2, cnt: 1,   exp_vs: 1'b1, exp_lpf: 10'd263};
    vecs[9]  = '{low: 7, cnt: 2,   exp_vs: 1'b1, exp_lpf: 10'd263};
    vecs[10] = '{low: 1, cnt: 1,   exp_vs: 1'b1, exp_lpf: 10'd263};
    vecs[11] = '{low: 7, cnt: 2,   exp_vs: 1'b1, exp_lpf: 10'd263};
    vecs[12] = '{low: 2, cnt: 1,   exp_vs: 1'b1, exp_lpf: 10'd263};
    vecs[13] = '{low: 3, cnt: 2,   exp_vs: 1'b1, exp_lpf: 10'd263};
    vecs[14] = '{low: 3, cnt: 1,   exp_vs: 1'b0, exp_lpf: 10'd3};

    csync_in = 1'b1;
    rst_in   = 1'b1;
    repeat (3) @(negedge clk_in);
    check_out("reset", 1'b1, 10'd0);
    check("reset_lost", 16'(sync_lost), 16'd0);
    rst_in = 1'b0;
    repeat (5) @(negedge clk_in);

    // Normal pulses only: vsync never asserts
    for (int p = 0; p < 400; p++) begin
      pulse(1, HIGH);
      check_out($sformatf("norm400_p%0d", p), 1'b1, 10'd0);
    end
    check("norm400_lost", 16'(sync_lost), 16'd0);

    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (5) @(negedge clk_in);

    for (int g = 0; g < int'(NVEC); g++) begin
      for (int p = 0; p < int'(vecs[g].cnt); p++) begin
        pulse(vecs[g].low, HIGH);
        check_out($sformatf("vec%0d_p%0d", g, p), vecs[g].exp_vs, vecs[g].exp_lpf);
      end
    end
    check("table_lost", 16'(sync_lost), 16'd0);

    // vsync rises exactly 3 cycles after the normal pulse's csync rise
    csync_in = 1'b0;
    @(negedge clk_in);
    csync_in = 1'b1;
    @(posedge clk_in); #1 check("rise_e1", 16'(vsync_out), 16'd0);
    @(posedge clk_in); #1 check("rise_e2", 16'(vsync_out), 16'd0);
    @(posedge clk_in); #1 check("rise_e3", 16'(vsync_out), 16'd1);
    @(negedge clk_in);
    repeat (HIGH) @(negedge clk_in);

    // vsync falls exactly 3 cycles after the third broad rise
    pulse(7, HIGH);
    pulse(7, HIGH);
    csync_in = 1'b0;
    repeat (7) @(negedge clk_in);
    csync_in = 1'b1;
    @(posedge clk_in); #1 check("fall_e1", 16'(vsync_out), 16'd1);
    @(posedge clk_in); #1 check("fall_e2", 16'(vsync_out), 16'd1);
    @(posedge clk_in); #1 check("fall_e3", 16'(vsync_out), 16'd0);
    check("fall_e3_lpf", 16'(lines_per_field), 16'd1);
    @(negedge clk_in);
    repeat (HIGH) @(negedge clk_in);

    // Reset during VSYNC: outputs clear before any clock edge
    rst_in = 1'b1;
    #1 check_out("async_rst", 1'b1, 10'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_in);
      #1 check($sformatf("post_rst_c%0d_vsync", i), 16'(vsync_out), 16'd1);
    end
    @(negedge clk_in);
    pulse(7, HIGH);
    pulse(7, HIGH);
    check_out("rst_b2", 1'b1, 10'd0);
    pulse(7, HIGH);
    check_out("rst_b3", 1'b0, 10'd0);

    // A pulse already low at reset release is not classified
    rst_in   = 1'b1;
    csync_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (10) @(negedge clk_in);
    csync_in = 1'b1;
    repeat (HIGH) @(negedge clk_in);
    check_out("inprog_rel", 1'b1, 10'd0);
    pulse(7, HIGH);
    pulse(7, HIGH);
    check_out("inprog_b2", 1'b1, 10'd0);
    pulse(7, HIGH);
    check_out("inprog_b3", 1'b0, 10'd0);

`ifdef SYNC_LOSS_EN
    repeat (200) @(negedge clk_in);
    check("loss_pre_lost", 16'(sync_lost), 16'd0);
    check("loss_pre_vsync", 16'(vsync_out), 16'd0);
    repeat (60) @(negedge clk_in);
    check("loss_lost", 16'(sync_lost), 16'd1);
    check("loss_vsync", 16'(vsync_out), 16'd1);
    pulse(1, HIGH);
    check("loss_clear_lost", 16'(sync_lost), 16'd0);
    check("loss_clear_vsync", 16'(vsync_out), 16'd1);
`else
    repeat (300) @(negedge clk_in);
    check("idle_lost", 16'(sync_lost), 16'd0);
    check("idle_vsync_hold", 16'(vsync_out), 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
